fetch_stage: RTL and testbench

IF stage plus IF/ID pipeline register for the 16-bit WISC pipeline. The block directly feeds the ID-stage control decoder.
- Holds the PC and drives the I-cache read handshake.
- Applies stall and redirect (branch/call/ret) requests from later stages.
- Stops fetching on HLT.
- Presents if_id_inst/if_id_pc_inc to ID, and drives flush_id into the decoder's Control_Flush to mark bubbles.

---
 rtl/fetch_stage_pkg.sv | 30 +++
 rtl/fetch_stage_if_id_reg.sv | 29 ++
 rtl/fetch_stage.sv | 106 ++++++++++
 tb/tb_fetch_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the WISC fetch stage: FSM encoding, opcodes and NOP word.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam logic [15:0] NOP_INST = 16'h0000;

    // Opcode field inst[15:12], shared with the ID-stage decoder.
    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+inc and valid, with hold/load/bubble controls.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [15:0] d_inst,
    input  logic [15:0] d_pc_inc,
    output logic [15:0] inst,
    output logic [15:0] pc_inc,
    output logic        valid
);

    // Bubble wins over load; neither asserted means hold.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            inst   <= NOP_INST;
            pc_inc <= '0;
            valid  <= 1'b0;
        end else if (load) begin
            inst   <= d_inst;
            pc_inc <= d_pc_inc;
            valid  <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// WISC IF stage: PC, I-cache read handshake, redirect/stall/halt handling, feeding IF/ID.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = OP_HLT,
    parameter logic [15:0] PC_INC      = 16'd1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        icache_re,
    output logic [15:0] icache_addr,
    input  logic        icache_rdy,
    input  logic [15:0] icache_data,
    input  logic        stall_id,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] if_id_inst,
    output logic [15:0] if_id_pc_inc,
    output logic        if_id_valid,
    output logic        flush_id,
    output logic        halted
);

    fetch_state_t state;
    logic [15:0]  pc;
    logic [15:0]  pend_pc;
    logic [15:0]  pc_seq;
    logic         ifid_load;
    logic         ifid_bubble;

    assign pc_seq = pc + PC_INC;

    always_comb begin
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        case (state)
            FETCH: begin
                if (redirect)        ifid_bubble = 1'b1;
                else if (stall_id)   ifid_bubble = 1'b0;
                else if (icache_rdy) ifid_load   = 1'b1;
                else                 ifid_bubble = 1'b1;
            end
            DRAIN:   ifid_bubble = redirect || !stall_id;
            HALT:    ifid_bubble = redirect || !stall_id;
            default: ifid_bubble = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            pend_pc <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect && icache_rdy) begin
                        pc <= redirect_pc;
                    end else if (redirect) begin
                        // Miss still in flight: keep address stable until it returns.
                        pend_pc <= redirect_pc;
                        state   <= DRAIN;
                    end else if (!stall_id && icache_rdy) begin
                        pc <= pc_seq;
                        if (icache_data[15:12] == HALT_OPCODE)
                            state <= HALT;
                    end
                end
                DRAIN: begin
                    if (redirect)
                        pend_pc <= redirect_pc;
                    if (icache_rdy) begin
                        pc    <= redirect ? redirect_pc : pend_pc;
                        state <= FETCH;
                    end
                end
                HALT: begin
                    if (redirect) begin
                        pc    <= redirect_pc;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (ifid_load),
        .bubble   (ifid_bubble),
        .d_inst   (icache_data),
        .d_pc_inc (pc_seq),
        .inst     (if_id_inst),
        .pc_inc   (if_id_pc_inc),
        .valid    (if_id_valid)
    );

    assign icache_re   = (state != HALT);
    assign icache_addr = pc;
    assign flush_id    = ~if_id_valid;
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a per-cycle reference model and literal spot checks.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_re;
    logic [15:0] icache_addr;
    logic        icache_rdy;
    logic [15:0] icache_data;
    logic        stall_id;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] if_id_inst;
    logic [15:0] if_id_pc_inc;
    logic        if_id_valid;
    logic        flush_id;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC    (16'h0000),
        .HALT_OPCODE (4'hF),
        .PC_INC      (16'd1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .icache_re    (icache_re),
        .icache_addr  (icache_addr),
        .icache_rdy   (icache_rdy),
        .icache_data  (icache_data),
        .stall_id     (stall_id),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_id_inst   (if_id_inst),
        .if_id_pc_inc (if_id_pc_inc),
        .if_id_valid  (if_id_valid),
        .flush_id     (flush_id),
        .halted       (halted)
    );

    function automatic logic [15:0] imem(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1123;
            16'h0001: return 16'h2456;
            16'h000A: return 16'hF000;
            default:  return {4'h1, a[11:0]};
        endcase
    endfunction

    assign icache_data = imem(icache_addr);

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what IF/ID and the fetch address must be, by the rules.
    logic [15:0] m_pc, m_pend, m_inst, m_pcinc;
    bit          m_valid, m_draining, m_halted;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 16'h0000; m_pend = 16'h0000; m_draining = 0; m_halted = 0;
            m_inst = 16'h0000; m_pcinc = 16'h0000; m_valid = 0;
        end else if (m_halted) begin
            if (redirect) begin
                m_pc = redirect_pc; m_halted = 0; m_inst = 0; m_valid = 0;
            end else if (!stall_id) begin
                m_inst = 0; m_valid = 0;
            end
        end else if (m_draining) begin
            if (redirect) m_pend = redirect_pc;
            if (redirect || !stall_id) begin
                m_inst = 0; m_valid = 0;
            end
            if (icache_rdy) begin
                m_pc = m_pend; m_draining = 0;
            end
        end else begin
            if (redirect) begin
                m_inst = 0; m_valid = 0;
                if (icache_rdy) m_pc = redirect_pc;
                else begin
                    m_pend = redirect_pc; m_draining = 1;
                end
            end else if (stall_id) begin
                // everything holds
            end else if (icache_rdy) begin
                m_inst = icache_data; m_valid = 1;
                m_pc = m_pc + 16'd1; m_pcinc = m_pc;
                if (icache_data[15:12] == 4'hF) m_halted = 1;
            end else begin
                m_inst = 0; m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_addr",   icache_addr, m_pc);
            check("m_re",     {15'd0, icache_re}, {15'd0, !m_halted});
            check("m_halted", {15'd0, halted}, {15'd0, m_halted});
            check("m_valid",  {15'd0, if_id_valid}, {15'd0, m_valid});
            check("m_flush",  {15'd0, flush_id}, {15'd0, !m_valid});
            check("m_inst",   if_id_inst, m_inst);
            if (m_valid) check("m_pcinc", if_id_pc_inc, m_pcinc);
        end
    end

    task automatic cyc(input logic r, input logic s, input logic rd, input logic [15:0] rp);
        icache_rdy = r; stall_id = s; redirect = rd; redirect_pc = rp;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit_if(input string name, input logic [15:0] inst, input logic [15:0] pcinc);
        check({name, "_inst"}, if_id_inst, inst);
        check({name, "_pcinc"}, if_id_pc_inc, pcinc);
        check({name, "_flush"}, {15'd0, flush_id}, 16'd0);
    endtask

    task automatic lit_bubble(input string name, input logic [15:0] addr);
        check({name, "_addr"}, icache_addr, addr);
        check({name, "_inst"}, if_id_inst, 16'h0000);
        check({name, "_flush"}, {15'd0, flush_id}, 16'd1);
    endtask

    initial begin
        rst = 1'b1;
        cyc(1, 0, 0, 16'h0);
        chk_en = 1'b1;
        cyc(1, 0, 0, 16'h0);
        lit_bubble("reset", 16'h0000);
        check("reset_halted", {15'd0, halted}, 16'd0);
        check("reset_re", {15'd0, icache_re}, 16'd1);
        rst = 1'b0;

        // Streaming hits from reset.
        cyc(1, 0, 0, 16'h0); lit_if("hit0", 16'h1123, 16'h0001);
        cyc(1, 0, 0, 16'h0); lit_if("hit1", 16'h2456, 16'h0002);
        cyc(1, 0, 0, 16'h0);
        cyc(1, 0, 0, 16'h0); lit_if("hit3", 16'h1003, 16'h0004);

        // Three-cycle miss at pc 4.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 16'h0); lit_bubble("miss", 16'h0004);
        end
        cyc(1, 0, 0, 16'h0); lit_if("after_miss", 16'h1004, 16'h0005);

        // Stall with cache ready: hold, then resume without skipping.
        cyc(1, 1, 0, 16'h0); lit_if("stall0", 16'h1004, 16'h0005);
        cyc(1, 1, 0, 16'h0); lit_if("stall1", 16'h1004, 16'h0005);
        check("stall_addr", icache_addr, 16'h0005);
        cyc(1, 0, 0, 16'h0); lit_if("unstall", 16'h1005, 16'h0006);
        cyc(1, 0, 0, 16'h0);
        cyc(1, 0, 0, 16'h0);

        // Redirect during a miss at pc 8; second redirect in DRAIN wins.
        cyc(0, 0, 1, 16'h0030); lit_bubble("drain0", 16'h0008);
        cyc(0, 1, 1, 16'h0040); lit_bubble("drain1", 16'h0008);
        cyc(0, 1, 0, 16'h0);    lit_bubble("drain2", 16'h0008);
        cyc(1, 0, 0, 16'h0);    lit_bubble("drain_done", 16'h0040);
        cyc(1, 0, 0, 16'h0);    lit_if("after_drain", 16'h1040, 16'h0041);

        // Redirect on a hit, then fetch HLT at pc 10.
        cyc(1, 0, 1, 16'h000A); lit_bubble("redir_hit", 16'h000A);
        cyc(1, 0, 0, 16'h0);    lit_if("hlt", 16'hF000, 16'h000B);
        check("hlt_halted", {15'd0, halted}, 16'd1);
        check("hlt_re", {15'd0, icache_re}, 16'd0);
        cyc(1, 1, 0, 16'h0);    lit_if("hlt_stall", 16'hF000, 16'h000B);
        cyc(1, 0, 0, 16'h0);    lit_bubble("halt_bubble", 16'h000B);
        cyc(1, 0, 0, 16'h0);    lit_bubble("halt_bubble2", 16'h000B);

        // Redirect out of HALT beats stall.
        cyc(1, 1, 1, 16'h0020); lit_bubble("unhalt", 16'h0020);
        check("unhalt_halted", {15'd0, halted}, 16'd0);
        cyc(1, 0, 0, 16'h0);    lit_if("unhalt_hit", 16'h1020, 16'h0021);

        // PC wrap at 16'hFFFF.
        cyc(1, 0, 1, 16'hFFFF); lit_bubble("wrap_redir", 16'hFFFF);
        cyc(1, 0, 0, 16'h0);    lit_if("wrap", 16'h1FFF, 16'h0000);
        check("wrap_addr", icache_addr, 16'h0000);
        cyc(1, 0, 0, 16'h0);    lit_if("wrap_next", 16'h1123, 16'h0001);

        // Reset in the middle of a drained miss.
        cyc(0, 0, 1, 16'h0050); lit_bubble("pre_rst", 16'h0001);
        rst = 1'b1;
        cyc(0, 0, 0, 16'h0);    lit_bubble("mid_rst", 16'h0000);
        check("mid_rst_halted", {15'd0, halted}, 16'd0);
        rst = 1'b0;
        cyc(1, 0, 0, 16'h0);    lit_if("post_rst", 16'h1123, 16'h0001);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
